// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier: exponent bias,
// word width and round-mode encodings.
package fp_pkg;

    localparam logic RND_TRUNC = 1'b0;
    localparam logic RND_RNE   = 1'b1;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Final-stage combinational logic: normalise the raw mantissa product, round it,
// detect range errors and pack the result word.
module fp_round_norm
    import fp_pkg::*;
#(
    parameter int EXP_W = 7,
    parameter int MAN_W = 16
) (
    input  logic                      sign,
    input  logic signed [EXP_W+1:0]   exp_in,
    input  logic                      zero,
    input  logic                      round_mode,
    input  logic [2*MAN_W+1:0]        product,
    output logic [EXP_W+MAN_W:0]      result,
    output logic                      overflow,
    output logic                      underflow
);
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EXP_W+1:0] EXP_ONE = {{(EXP_W + 1){1'b0}}, 1'b1};
    localparam logic signed [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    logic [PW-2:0]           norm;
    logic signed [EXP_W+1:0] exp_norm;
    logic signed [EXP_W+1:0] exp_fin;
    logic [MAN_W:0]          man_rnd;
    logic [MAN_W-1:0]        man_fin;
    logic                    guard;
    logic                    sticky;
    logic                    inc;

    // norm drops the hidden bit: fraction sits at the top, then guard, then sticky bits.
    always_comb begin
        if (product[PW-1]) begin
            norm     = product[PW-2:0];
            exp_norm = exp_in + EXP_ONE;
        end else begin
            norm     = {product[PW-3:0], 1'b0};
            exp_norm = exp_in;
        end

        guard   = norm[MAN_W];
        sticky  = |norm[MAN_W-1:0];
        inc     = (round_mode == RND_RNE) && guard && (sticky || norm[MAN_W+1]);
        man_rnd = {1'b0, norm[PW-2:MAN_W+1]} + {{MAN_W{1'b0}}, inc};

        if (man_rnd[MAN_W]) begin
            man_fin = '0;
            exp_fin = exp_norm + EXP_ONE;
        end else begin
            man_fin = man_rnd[MAN_W-1:0];
            exp_fin = exp_norm;
        end

        overflow  = 1'b0;
        underflow = 1'b0;
        result    = {sign, exp_fin[EXP_W-1:0], man_fin};
        if (zero) begin
            result = {sign, {(EXP_W + MAN_W){1'b0}}};
        end else if (exp_fin > EXP_MAX) begin
            overflow = 1'b1;
            result   = {sign, {(EXP_W + MAN_W){1'b1}}};
        end else if (exp_fin < EXP_ONE) begin
            underflow = 1'b1;
            result    = {sign, {(EXP_W + MAN_W){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with a tag sideband; every
// stage advances together, so one downstream stall freezes the whole pipe.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 7,
    parameter int MAN_W = 16,
    parameter int TAG_W = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [fp_width(EXP_W, MAN_W)-1:0] float_a,
    input  logic [fp_width(EXP_W, MAN_W)-1:0] float_b,
    input  logic [TAG_W-1:0]                  in_tag,
    input  logic                              round_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [fp_width(EXP_W, MAN_W)-1:0] float_out,
    output logic [TAG_W-1:0]                  out_tag,
    output logic                              float_out_overflow,
    output logic                              float_out_underflow
);
    localparam int W  = fp_width(EXP_W, MAN_W);
    localparam int EW = EXP_W + 2;
    localparam int MW = MAN_W + 1;
    localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));

    logic [EXP_W-1:0] a_exp;
    logic [EXP_W-1:0] b_exp;
    logic             advance;

    logic                 s1_valid_d, s1_valid_q;
    logic                 s1_sign_d, s1_sign_q;
    logic signed [EW-1:0] s1_exp_d, s1_exp_q;
    logic                 s1_zero_d, s1_zero_q;
    logic [MW-1:0]        s1_man_a_d, s1_man_a_q;
    logic [MW-1:0]        s1_man_b_d, s1_man_b_q;
    logic [TAG_W-1:0]     s1_tag_d, s1_tag_q;
    logic                 s1_rm_d, s1_rm_q;

    logic                 s2_valid_d, s2_valid_q;
    logic                 s2_sign_d, s2_sign_q;
    logic signed [EW-1:0] s2_exp_d, s2_exp_q;
    logic                 s2_zero_d, s2_zero_q;
    logic [2*MW-1:0]      s2_prod_d, s2_prod_q;
    logic [TAG_W-1:0]     s2_tag_d, s2_tag_q;
    logic                 s2_rm_d, s2_rm_q;

    logic                 out_valid_d, out_valid_q;
    logic [W-1:0]         float_out_d, float_out_q;
    logic [TAG_W-1:0]     out_tag_d, out_tag_q;
    logic                 overflow_d, overflow_q;
    logic                 underflow_d, underflow_q;

    logic [W-1:0]         rn_result;
    logic                 rn_overflow;
    logic                 rn_underflow;

    assign a_exp    = float_a[W-2:MAN_W];
    assign b_exp    = float_b[W-2:MAN_W];
    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_exp_d    = s1_exp_q;
        s1_zero_d   = s1_zero_q;
        s1_man_a_d  = s1_man_a_q;
        s1_man_b_d  = s1_man_b_q;
        s1_tag_d    = s1_tag_q;
        s1_rm_d     = s1_rm_q;
        s2_valid_d  = s2_valid_q;
        s2_sign_d   = s2_sign_q;
        s2_exp_d    = s2_exp_q;
        s2_zero_d   = s2_zero_q;
        s2_prod_d   = s2_prod_q;
        s2_tag_d    = s2_tag_q;
        s2_rm_d     = s2_rm_q;
        out_valid_d = out_valid_q;
        float_out_d = float_out_q;
        out_tag_d   = out_tag_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (advance) begin
            s1_valid_d = in_valid;
            s1_sign_d  = float_a[W-1] ^ float_b[W-1];
            s1_exp_d   = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;
            s1_zero_d  = (a_exp == '0) || (b_exp == '0);
            s1_man_a_d = {1'b1, float_a[MAN_W-1:0]};
            s1_man_b_d = {1'b1, float_b[MAN_W-1:0]};
            s1_tag_d   = in_tag;
            s1_rm_d    = round_mode;

            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_exp_d   = s1_exp_q;
            s2_zero_d  = s1_zero_q;
            s2_prod_d  = {{MW{1'b0}}, s1_man_a_q} * {{MW{1'b0}}, s1_man_b_q};
            s2_tag_d   = s1_tag_q;
            s2_rm_d    = s1_rm_q;

            // Output data only changes for real results, so bubbles leave the last value in place.
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                float_out_d = rn_result;
                out_tag_d   = s2_tag_q;
                overflow_d  = rn_overflow;
                underflow_d = rn_underflow;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            float_out_q <= '0;
            out_tag_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            float_out_q <= float_out_d;
            out_tag_q   <= out_tag_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Data-path stage registers are qualified by the valids and need no reset.
    always_ff @(posedge clk) begin
        s1_sign_q  <= s1_sign_d;
        s1_exp_q   <= s1_exp_d;
        s1_zero_q  <= s1_zero_d;
        s1_man_a_q <= s1_man_a_d;
        s1_man_b_q <= s1_man_b_d;
        s1_tag_q   <= s1_tag_d;
        s1_rm_q    <= s1_rm_d;
        s2_sign_q  <= s2_sign_d;
        s2_exp_q   <= s2_exp_d;
        s2_zero_q  <= s2_zero_d;
        s2_prod_q  <= s2_prod_d;
        s2_tag_q   <= s2_tag_d;
        s2_rm_q    <= s2_rm_d;
    end

    fp_round_norm #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round_norm (
        .sign      (s2_sign_q),
        .exp_in    (s2_exp_q),
        .zero      (s2_zero_q),
        .round_mode(s2_rm_q),
        .product   (s2_prod_q),
        .result    (rn_result),
        .overflow  (rn_overflow),
        .underflow (rn_underflow)
    );

    assign out_valid           = out_valid_q;
    assign float_out           = float_out_q;
    assign out_tag             = out_tag_q;
    assign float_out_overflow  = overflow_q;
    assign float_out_underflow = underflow_q;

endmodule
